// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, coordinate width and raster output bundle
// for the pong raster stage.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  // Everything the renderer sees, registered together so it stays aligned.
  typedef struct packed {
    logic               pix_en;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic               line_tick;
    logic               frame_tick;
    logic [COORD_W-1:0] column;
    logic [COORD_W-1:0] row;
  } vga_out_t;

  // Half-open window test [lo, hi) on a coordinate.
  function automatic logic in_window(logic [COORD_W-1:0] v,
                                     logic [COORD_W-1:0] lo,
                                     logic [COORD_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-MAX counter advancing on en; wrap flags the enabled step out of MAX-1.
module vga_wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned MAX = DEF_H_TOTAL,
  parameter int unsigned W   = COORD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  assign wrap = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters and a single aligned
// output register stage (syncs, video gate, coordinates, line/frame ticks).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] column,
  output logic [COORD_W-1:0] row,
  output logic               line_tick,
  output logic               frame_tick
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_ACT_C      = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C      = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] H_SYNC_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] H_SYNC_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_SYNC_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] V_SYNC_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0]   div;
  logic               step;
  logic               eol;
  logic               eof;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  vga_out_t           out_nxt;
  vga_out_t           out_q;

  // Pixel-rate divider; with CLK_DIV=1 div stays 0 and step is always high.
  assign step = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (step) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  vga_wrap_counter #(
    .MAX (H_TOTAL),
    .W   (COORD_W)
  ) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (step),
    .cnt   (h_cnt),
    .wrap  (eol)
  );

  vga_wrap_counter #(
    .MAX (V_TOTAL),
    .W   (COORD_W)
  ) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (eol),
    .cnt   (v_cnt),
    .wrap  (eof)
  );

  // Decode the current counter state; registered below as one aligned bundle.
  always_comb begin
    out_nxt            = '0;
    out_nxt.pix_en     = step;
    out_nxt.line_tick  = eol;
    out_nxt.frame_tick = eof;
    out_nxt.column     = h_cnt;
    out_nxt.row        = v_cnt;
    out_nxt.video_on   = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    out_nxt.hsync      = in_window(h_cnt, H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    out_nxt.vsync      = in_window(v_cnt, V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      out_q.hsync <= ~SYNC_POL;
      out_q.vsync <= ~SYNC_POL;
    end else begin
      out_q <= out_nxt;
    end
  end

  assign pix_en     = out_q.pix_en;
  assign hsync      = out_q.hsync;
  assign vsync      = out_q.vsync;
  assign video_on   = out_q.video_on;
  assign column     = out_q.column;
  assign row        = out_q.row;
  assign line_tick  = out_q.line_tick;
  assign frame_tick = out_q.frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing plus two reduced rasters
// (15x10) so whole frames and mid-frame reset fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ab;
  logic rst_c;

  logic       a_pix, a_hs, a_vs, a_vid, a_lt, a_ft;
  logic [9:0] a_col, a_row;
  logic       b_pix, b_hs, b_vs, b_vid, b_lt, b_ft;
  logic [9:0] b_col, b_row;
  logic       c_pix, c_hs, c_vs, c_vid, c_lt, c_ft;
  logic [9:0] c_col, c_row;

  vga_timing_gen u_a (
    .clk(clk), .reset(rst_ab), .pix_en(a_pix), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_vid), .column(a_col), .row(a_row), .line_tick(a_lt), .frame_tick(a_ft)
  );

  // 15 columns x 10 rows, pixel every clk, active-high syncs: frame = 150 clks
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .SYNC_POL(1'b1)
  ) u_b (
    .clk(clk), .reset(rst_ab), .pix_en(b_pix), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_vid), .column(b_col), .row(b_row), .line_tick(b_lt), .frame_tick(b_ft)
  );

  // Same raster, CLK_DIV=2, active-low syncs: frame = 300 clks
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .SYNC_POL(1'b0)
  ) u_c (
    .clk(clk), .reset(rst_c), .pix_en(c_pix), .hsync(c_hs), .vsync(c_vs),
    .video_on(c_vid), .column(c_col), .row(c_row), .line_tick(c_lt), .frame_tick(c_ft)
  );

  typedef struct {
    int dut;   // 0 = u_a, 1 = u_b
    int k;     // clk edge number after reset release
    int col;
    int row;
    bit vid;
    bit hs;
    bit vs;
    bit pix;
    bit lt;
    bit ft;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int dut, input int k, input int col, input int row, input bit vid,
                     input bit hs, input bit vs, input bit pix, input bit lt, input bit ft);
    vec_t v;
    v.dut = dut; v.k = k; v.col = col; v.row = row; v.vid = vid;
    v.hs = hs; v.vs = vs; v.pix = pix; v.lt = lt; v.ft = ft;
    tbl.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v);
    string t;
    t = $sformatf("%s@%0d", (v.dut == 0) ? "A" : "B", v.k);
    if (v.dut == 0) begin
      chk({t, ".column"}, int'(a_col), v.col);   chk({t, ".row"}, int'(a_row), v.row);
      chk({t, ".video_on"}, int'(a_vid), int'(v.vid));
      chk({t, ".hsync"}, int'(a_hs), int'(v.hs)); chk({t, ".vsync"}, int'(a_vs), int'(v.vs));
      chk({t, ".pix_en"}, int'(a_pix), int'(v.pix));
      chk({t, ".line_tick"}, int'(a_lt), int'(v.lt));
      chk({t, ".frame_tick"}, int'(a_ft), int'(v.ft));
    end else begin
      chk({t, ".column"}, int'(b_col), v.col);   chk({t, ".row"}, int'(b_row), v.row);
      chk({t, ".video_on"}, int'(b_vid), int'(v.vid));
      chk({t, ".hsync"}, int'(b_hs), int'(v.hs)); chk({t, ".vsync"}, int'(b_vs), int'(v.vs));
      chk({t, ".pix_en"}, int'(b_pix), int'(v.pix));
      chk({t, ".line_tick"}, int'(b_lt), int'(v.lt));
      chk({t, ".frame_tick"}, int'(b_ft), int'(v.ft));
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int a_pix_n, a_lt_n, a_hs_low, a_vid_n, a_hold_bad;
    int b_pix_low, b_ft_n, b_vs_high, b_coinc_bad, b_ft_gap_bad, b_last_ft, b_first_ft;
    int c_vs_low, c_ft_n, c_lt_n, c_first_ft;
    int prev_col;
    bit prev_pix;
    bit found;
    int got;

    a_pix_n = 0; a_lt_n = 0; a_hs_low = 0; a_vid_n = 0; a_hold_bad = 0;
    b_pix_low = 0; b_ft_n = 0; b_vs_high = 0; b_coinc_bad = 0; b_ft_gap_bad = 0;
    b_last_ft = 0; b_first_ft = 0;
    c_vs_low = 0; c_ft_n = 0; c_lt_n = 0; c_first_ft = 0;
    prev_col = 0; prev_pix = 1'b0;

    //   dut  k     col  row vid hs vs pix lt ft
    add(0,    1,    0,   0,  1,  1, 1, 0,  0, 0);
    add(0,    2,    0,   0,  1,  1, 1, 1,  0, 0);
    add(0,    3,    1,   0,  1,  1, 1, 0,  0, 0);
    add(0,    1280, 639, 0,  1,  1, 1, 1,  0, 0);
    add(0,    1281, 640, 0,  0,  1, 1, 0,  0, 0);
    add(0,    1312, 655, 0,  0,  1, 1, 1,  0, 0);
    add(0,    1313, 656, 0,  0,  0, 1, 0,  0, 0);
    add(0,    1504, 751, 0,  0,  0, 1, 1,  0, 0);
    add(0,    1505, 752, 0,  0,  1, 1, 0,  0, 0);
    add(0,    1600, 799, 0,  0,  1, 1, 1,  1, 0);
    add(0,    1601, 0,   1,  1,  1, 1, 0,  0, 0);
    add(0,    3200, 799, 1,  0,  1, 1, 1,  1, 0);
    add(1,    1,    0,   0,  1,  0, 0, 1,  0, 0);
    add(1,    11,   10,  0,  0,  1, 0, 1,  0, 0);
    add(1,    15,   14,  0,  0,  0, 0, 1,  1, 0);
    add(1,    106,  0,   7,  0,  0, 1, 1,  0, 0);
    add(1,    150,  14,  9,  0,  0, 0, 1,  1, 1);
    add(1,    151,  0,   0,  1,  0, 0, 1,  0, 0);

    // Reset held 5 clks
    rst_ab = 1'b1;
    rst_c  = 1'b1;
    repeat (5) edge_step();
    chk("A.rst.column", int'(a_col), 0);  chk("A.rst.row", int'(a_row), 0);
    chk("A.rst.video_on", int'(a_vid), 0); chk("A.rst.pix_en", int'(a_pix), 0);
    chk("A.rst.hsync", int'(a_hs), 1);    chk("A.rst.vsync", int'(a_vs), 1);
    chk("A.rst.ticks", int'({a_lt, a_ft}), 0);
    chk("B.rst.hsync", int'(b_hs), 0);    chk("B.rst.vsync", int'(b_vs), 0);
    chk("B.rst.pix_en", int'(b_pix), 0);  chk("B.rst.video_on", int'(b_vid), 0);
    chk("C.rst.syncs", int'({c_hs, c_vs}), 3);

    rst_ab = 1'b0;
    rst_c  = 1'b0;
    for (int k = 1; k <= 3200; k++) begin
      edge_step();
      foreach (tbl[i]) if (tbl[i].k == k) apply_vec(tbl[i]);

      if (k <= 1600) begin
        a_pix_n  += int'(a_pix);
        a_lt_n   += int'(a_lt);
        a_hs_low += int'(!a_hs);
        a_vid_n  += int'(a_vid);
      end
      // column may change only right after a pix_en, and must change then
      if (k > 1 && ((int'(a_col) != prev_col) != prev_pix)) a_hold_bad++;
      prev_col = int'(a_col);
      prev_pix = a_pix;

      b_pix_low += int'(!b_pix);
      b_vs_high += int'(b_vs);
      if (b_ft) begin
        b_ft_n++;
        if (!(b_lt && b_pix) || b_row != 10'd9) b_coinc_bad++;
        if (b_first_ft == 0) b_first_ft = k;
        else if (k - b_last_ft != 150) b_ft_gap_bad++;
        b_last_ft = k;
      end

      if (k <= 300) c_vs_low += int'(!c_vs);
      c_lt_n += int'(c_lt);
      if (c_ft) begin
        c_ft_n++;
        if (c_first_ft == 0) c_first_ft = k;
      end
    end

    chk("A.line.pix_en_count", a_pix_n, 800);
    chk("A.line.line_tick_count", a_lt_n, 1);
    chk("A.line.hsync_low_clks", a_hs_low, 192);
    chk("A.line.video_on_clks", a_vid_n, 1280);
    chk("A.column_hold_violations", a_hold_bad, 0);
    chk("B.pix_en_low_clks", b_pix_low, 0);
    chk("B.vsync_high_clks", b_vs_high, 630);
    chk("B.frame_tick_count", b_ft_n, 21);
    chk("B.first_frame_tick", b_first_ft, 150);
    chk("B.frame_period_violations", b_ft_gap_bad, 0);
    chk("B.frame_tick_alignment", b_coinc_bad, 0);
    chk("C.frame.vsync_low_clks", c_vs_low, 60);
    chk("C.first_frame_tick", c_first_ft, 300);
    chk("C.frame_tick_count", c_ft_n, 10);
    chk("C.line_tick_count", c_lt_n, 106);

    // Mid-frame reset on C at row 5, column 4
    found = 1'b0;
    for (int n = 0; n < 700 && !found; n++) begin
      edge_step();
      if (c_col == 10'd4 && c_row == 10'd5) found = 1'b1;
    end
    chk("C.reach_mid_frame", int'(found), 1);
    rst_c = 1'b1;
    edge_step();
    chk("C.midrst.column", int'(c_col), 0); chk("C.midrst.row", int'(c_row), 0);
    chk("C.midrst.video_on", int'(c_vid), 0);
    chk("C.midrst.pix_ticks", int'({c_pix, c_lt, c_ft}), 0);
    chk("C.midrst.syncs", int'({c_hs, c_vs}), 3);
    rst_c = 1'b0;
    got = 0;
    for (int n = 1; n <= 400 && got == 0; n++) begin
      edge_step();
      if (n == 1) begin
        chk("C.release.coords", int'({c_col, c_row}), 0);
        chk("C.release.video_on", int'(c_vid), 1);
        chk("C.release.syncs", int'({c_hs, c_vs}), 3);
      end
      if (c_ft) got = n;
    end
    chk("C.frame_after_reset", got, 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
